// File: rtl/imem_byte_arbiter_if.sv
// Bundles the request, memory and response signals of the instruction-memory arbiter.
// Latency: none; this is wiring only.
// Backpressure: req_ready grants requests; rsp_ready stalls the response channel.
interface imem_byte_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [1:0]        req_ready;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_addr0, req_addr1, mem_rdata, rsp_ready,
        output req_ready, mem_en, mem_addr, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    // The requesters, response consumer and memory array.
    modport master (
        output req_valid, req_addr0, req_addr1, mem_rdata, rsp_ready,
        input  req_ready, mem_en, mem_addr, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_byte_arbiter.sv
// Round-robin arbiter: two requesters share a byte-wide memory; four byte reads form a 32-bit big-endian word.
// Latency: accept in T, response valid in T+6 (T+1 for address errors); accept-to-accept spacing is at least 7 cycles.
// Backpressure: response is held stable until rsp_ready; no request is granted until then. Macro IMEM_ARB_ALIGN_CHECK_EN rejects unaligned addresses.
module imem_byte_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int MEM_SIZE = 4095
) (
    input  logic                clk,
    input  logic                reset,
    imem_byte_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

    // Highest base address whose four bytes all lie inside the memory.
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_SIZE - 4);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] base_addr;
    logic              rr_ptr;
    logic              rd_pend;
    logic [31:0]       word;
    logic              rsp_id_q;
    logic              rsp_err_q;

    logic              acc_id;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W:0]   acc_end;
    logic              acc_err;
    logic              accept;

    // Pick the requester that would win now and classify its address.
    always_comb begin
        acc_id = 1'b0;
        if (bus.req_valid == 2'b11) begin
            acc_id = rr_ptr;
        end else begin
            acc_id = bus.req_valid[1];
        end
        acc_addr = acc_id ? bus.req_addr1 : bus.req_addr0;
        // Extra carry bit catches base addresses whose last byte wraps past ADDR_W.
        acc_end  = {1'b0, acc_addr} + (ADDR_W + 1)'(3);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        acc_err  = (acc_addr > LAST_OK) || acc_end[ADDR_W] || (acc_addr[1:0] != 2'b00);
`else
        acc_err  = (acc_addr > LAST_OK) || acc_end[ADDR_W];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = 2'b00;
        bus.mem_en    = 1'b0;
        bus.mem_addr  = '0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Reset masks the grant so nothing is accepted in a reset cycle.
                if (!reset && (bus.req_valid != 2'b00)) begin
                    accept        = 1'b1;
                    bus.req_ready = acc_id ? 2'b10 : 2'b01;
                    state_nxt     = acc_err ? RESP : READ;
                end
            end
            READ: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_addr + {{(ADDR_W-2){1'b0}}, cnt};
                if (cnt == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, byte counter, round-robin pointer and word assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 2'd0;
            base_addr <= '0;
            rr_ptr    <= 1'b0;
            rd_pend   <= 1'b0;
            word      <= 32'd0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            // Memory returns data one cycle after the strobe.
            rd_pend <= bus.mem_en;
            if (rd_pend) begin
                word <= {word[23:0], bus.mem_rdata};
            end
            if (bus.mem_en) begin
                cnt <= cnt + 2'd1;
            end
            if (accept) begin
                base_addr <= acc_addr;
                rsp_id_q  <= acc_id;
                rsp_err_q <= acc_err;
                word      <= 32'd0;
                cnt       <= 2'd0;
                rr_ptr    <= ~acc_id;
            end
        end
    end

    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.rsp_data = word;
endmodule

// File: tb/tb_imem_byte_arbiter.sv
// Directed bench with a response scoreboard for imem_byte_arbiter.
// Latency: checks T+1..T+4 reads, T+6 response, T+1 error response, 7-cycle spacing.
// Backpressure: stalls rsp_ready and checks held outputs and blocked grants.
module tb_imem_byte_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_byte_arbiter_if #(.ADDR_W(64)) bus();

    imem_byte_arbiter #(.ADDR_W(64), .MEM_SIZE(4095)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mem [0:4095];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Synchronous-read memory model.
    always @(posedge clk) begin
        if (reset) bus.mem_rdata <= 8'd0;
        else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr[11:0]];
    end

    // Scoreboard monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_id",   64'(bus.rsp_id),   64'(mon_e.id));
                chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
                chk("rsp_err",  64'(bus.rsp_err),  64'(mon_e.err));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic id, input logic [31:0] data, input logic err);
        exp_t e;
        e.id = id; e.data = data; e.err = err;
        q.push_back(e);
    endtask

    task automatic wait_ready(input int port);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_ready[port]) begin ok = 1; break; end
        end
        if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    // Returns in cycle T+1 (just after the accepting edge).
    task automatic do_req(input int port, input logic [63:0] addr);
        @(posedge clk); #1;
        if (port == 0) bus.req_addr0 = addr; else bus.req_addr1 = addr;
        bus.req_valid[port] = 1'b1;
        wait_ready(port);
        @(posedge clk); #1;
        bus.req_valid[port] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("outputs_in_reset",
            64'({bus.req_ready, bus.mem_en, bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int  gid [4];
        int  gcyc[4];
        int  n;
        bit  ok;
        bit  bad;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h81;
        mem[8] = 8'hde; mem[9] = 8'had; mem[10] = 8'hbe; mem[11] = 8'hef;
        mem[4088] = 8'ha0; mem[4089] = 8'hb1; mem[4090] = 8'hc2;
        mem[4091] = 8'h01; mem[4092] = 8'h02; mem[4093] = 8'h03; mem[4094] = 8'h04;

        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({bus.req_ready, bus.mem_en, bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'd0);
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("reset_mem_addr", bus.mem_addr, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch: read timing and assembled word.
        push(1'b0, 32'h13050000, 1'b0);
        do_req(0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("read_mem_en", 64'(bus.mem_en), 64'd1);
            chk("read_mem_addr", bus.mem_addr, 64'(i));
        end
        @(negedge clk);
        chk("drain_mem_en_valid", 64'({bus.mem_en, bus.rsp_valid}), 64'd0);
        chk("drain_mem_addr", bus.mem_addr, 64'd0);
        @(negedge clk);
        chk("rsp_valid_t6", 64'(bus.rsp_valid), 64'd1);
        wait_idle();

        // Continuous contention: 0,1,0,1 every 7 cycles.
        pulse_reset();
        push(1'b0, 32'h13050000, 1'b0);
        push(1'b1, 32'hdeadbeef, 1'b0);
        push(1'b0, 32'h13050000, 1'b0);
        push(1'b1, 32'hdeadbeef, 1'b0);
        @(posedge clk); #1;
        bus.req_addr0 = 64'd0;
        bus.req_addr1 = 64'd8;
        bus.req_valid = 2'b11;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                chk("grant_onehot", 64'(bus.req_ready == 2'b01 || bus.req_ready == 2'b10), 64'd1);
                gid[n]  = bus.req_ready[1] ? 1 : 0;
                gcyc[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        chk("grant_count", 64'(n), 64'd4);
        for (int k = 0; k < 4; k++) chk("grant_order", 64'(gid[k]), 64'(k % 2));
        for (int k = 1; k < 4; k++) chk("grant_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd7);
        wait_idle();

        // Response stall: outputs held, no grant while stalled.
        bus.rsp_ready = 1'b0;
        push(1'b1, 32'hdeadbeef, 1'b0);
        do_req(1, 64'd8);
        push(1'b0, 32'h13050000, 1'b0);
        bus.req_addr0 = 64'd0;
        bus.req_valid[0] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("stall_rsp_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_hold",
                64'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data}),
                64'({1'b1, 1'b1, 1'b0, 32'hdeadbeef}));
            chk("stall_no_grant", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_no_grant", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("grant_after_handshake", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_idle();

        // Out-of-range address on requester 1.
        push(1'b1, 32'd0, 1'b1);
        do_req(1, 64'd4092);
        @(negedge clk);
        chk("err_rsp_t1", 64'({bus.rsp_valid, bus.mem_en}), 64'b10);
        wait_idle();

        // Address whose last byte wraps past ADDR_W.
        push(1'b0, 32'd0, 1'b1);
        do_req(0, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("ovf_rsp_t1", 64'({bus.rsp_valid, bus.mem_en}), 64'b10);
        wait_idle();

        // Highest aligned legal base.
        push(1'b1, 32'ha0b1c201, 1'b0);
        do_req(1, 64'd4088);
        wait_idle();

        // Highest legal unaligned base and an unaligned low address.
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        push(1'b1, 32'd0, 1'b1);
        do_req(1, 64'd4091);
        wait_idle();
        push(1'b0, 32'd0, 1'b1);
        do_req(0, 64'd2);
        @(negedge clk);
        chk("unaligned_err_t1", 64'({bus.rsp_valid, bus.mem_en}), 64'b10);
        wait_idle();
`else
        push(1'b1, 32'h01020304, 1'b0);
        do_req(1, 64'd4091);
        wait_idle();
        push(1'b0, 32'h00009381, 1'b0);
        do_req(0, 64'd2);
        wait_idle();
`endif

        // Reset mid-READ drops the operation and the pointer returns to 0.
        do_req(0, 64'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_quiet", 64'({bus.mem_en, bus.rsp_valid}), 64'd0);
        chk("post_reset_mem_addr", bus.mem_addr, 64'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_en || bus.rsp_valid) bad = 1;
        end
        chk("post_reset_stays_quiet", 64'(bad), 64'd0);
        push(1'b0, 32'h13050000, 1'b0);
        @(posedge clk); #1;
        bus.req_addr0 = 64'd0;
        bus.req_addr1 = 64'd8;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("ptr_after_reset", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_idle();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_byte_arbiter.md
Name: imem_byte_arbiter

Overview:
- Shares the byte-wide, big-endian instruction memory between two requesters: port 0 is instruction fetch, port 1 is the debug/loader read path.
- Arbitrates between the requesters with round-robin.
- For each granted request, issues four sequential byte reads to a synchronous-read memory and assembles one 32-bit big-endian word.
- Returns the word on a single valid/ready response channel tagged with the requester id.
- Sits between the fetch/debug logic and the memory array.

Parameters:
- ADDR_W, 64, address width of request and memory ports.
- MEM_SIZE, 4095, number of bytes in the memory; sets the legal address range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit 0 is fetch, bit 1 is debug.
- req_addr0  input  ADDR_W  byte address for requester 0.
- req_addr1  input  ADDR_W  byte address for requester 1.
- req_ready  output  2  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
- mem_en  output  1  byte read strobe to the memory.
- mem_addr  output  ADDR_W  byte address to the memory.
- mem_rdata  input  8  read byte; valid exactly one cycle after the mem_en cycle.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  32  assembled word, {byte@A, byte@A+1, byte@A+2, byte@A+3}.
- rsp_err  output  1  address error; rsp_data is 0 when set.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, round-robin pointer = requester 0.
- Reset is sampled every cycle. It aborts any in-flight operation immediately: no mem_en in the following cycle, any pending response is dropped.
- Request rules:
  - A requester holds req_valid and its address stable until it is granted.
  - req_ready is asserted only in IDLE and is a combinational function of req_valid and the pointer.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's requester is granted.
  - After each grant the pointer moves to the other requester, so back-to-back contention alternates 0,1,0,1.
- States: IDLE -> READ -> DRAIN -> RESP -> IDLE. There is also a direct path IDLE -> RESP for error requests.
- IDLE:
  - On an accept in cycle T, latch base address A and id.
  - If A > MEM_SIZE-4, or if A+3 overflows ADDR_W, go to RESP with rsp_err=1 and rsp_data=0, no memory access. rsp_valid is then high in T+1.
  - Otherwise go to READ.
- READ (cycles T+1..T+4):
  - mem_en=1, mem_addr = A + cnt, cnt = 0..3.
  - Each returned byte is shifted into the word, MSB first.
  - After cnt=3, go to DRAIN.
- DRAIN (T+5): mem_en=0; the last byte is captured at the end of this cycle.
- RESP:
  - rsp_valid=1 from T+6, with rsp_data, rsp_id and rsp_err held stable until rsp_ready.
  - On the handshake cycle, go to IDLE. req_ready may assert the following cycle.
  - Minimum accept-to-accept spacing is 7 cycles.
- mem_en is 0 in every state except READ. mem_addr is 0 whenever mem_en is 0.
- Address arithmetic is unsigned ADDR_W. Any unaligned A is legal unless the optional feature is enabled.

Optional Feature:
- Macro: IMEM_ARB_ALIGN_CHECK_EN.
- When defined, a request with A[1:0] != 0 is treated like an out-of-range request: no memory reads, rsp_err=1, rsp_data=0, rsp_valid in T+1.
- When not defined, unaligned addresses are read normally as four consecutive bytes.

Test Plan:
- Memory bytes 0..3 = 13 05 00 00; req_valid=01, addr0=0; rsp_ready=1 -> mem_en high T+1..T+4 at addresses 0,1,2,3; rsp_valid at T+6; rsp_data=32'h13050000, rsp_id=0, rsp_err=0.
- Both requesters valid continuously (addr0=0, addr1=8) with rsp_ready=1 -> grants alternate 0,1,0,1 starting with requester 0 after reset; rsp_id matches each grant order.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data, rsp_id and rsp_err stable; req_ready=00 throughout; next grant only after the handshake.
- addr1 = MEM_SIZE-3 (4092) -> no mem_en; rsp_valid in T+1 with rsp_err=1, rsp_data=0, rsp_id=1.
- Assert reset for 1 cycle at T+3 mid-READ -> from the next cycle mem_en=0, rsp_valid=0, pointer back to 0; a fresh request after reset completes normally.
- addr0=2: with IMEM_ARB_ALIGN_CHECK_EN defined -> rsp_err=1 in T+1; without it -> rsp_data = {mem[2],mem[3],mem[4],mem[5]}.
